// File: rtl/bip_pkg.sv
// Shared definitions for the BIP fetch/decode/control slice: field widths, opcodes,
// accumulator-mux encodings, FSM states and the control-strobe bundle.
package bip_pkg;

  localparam int unsigned INSTR_WIDTH   = 16;
  localparam int unsigned PC_WIDTH      = 11;
  localparam int unsigned OPCODE_WIDTH  = 5;
  localparam int unsigned OPERAND_WIDTH = 11;
  localparam int unsigned CNT_WIDTH     = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_EXT = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op_sub;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Purely combinational opcode-to-strobe decoder; HLT and all NOP opcodes yield no strobes.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output ctrl_t                   ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_STO: ctrl.wr_ram = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_a  = SELA_RAM;
        ctrl.wr_acc = 1'b1;
      end
      OP_LDI: begin
        ctrl.sel_a  = SELA_EXT;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_b  = 1'b0;
        ctrl.op_sub = (opcode == OP_SUB);
        ctrl.sel_a  = SELA_ALU;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.sel_b  = 1'b1;
        ctrl.op_sub = (opcode == OP_SUBI);
        ctrl.sel_a  = SELA_ALU;
        ctrl.wr_acc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP fetch/decode/control: PC register, FETCH/EXECUTE/HALT FSM, strobe gating.
// Optional BIP_CYCLE_COUNT_EN adds a saturating executed-cycle counter (CycleCount).
module bip_control
  import bip_pkg::*;
(
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic [INSTR_WIDTH-1:0]   Instr,
  output logic [PC_WIDTH-1:0]      Pc,
  output logic [OPERAND_WIDTH-1:0] Operand,
  output logic [1:0]               SelA,
  output logic                     SelB,
  output logic                     OpSub,
  output logic                     WrAcc,
  output logic                     WrRam,
  output logic                     RdRam,
  output logic                     Halted
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]     CycleCount
`endif
);

  state_t                state, state_next;
  logic [PC_WIDTH-1:0]   pc_next;
  logic [OPCODE_WIDTH-1:0] opcode;
  ctrl_t                 dec_ctrl, exec_ctrl;

  assign opcode = Instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];

  bip_decoder u_decoder (
    .opcode (opcode),
    .ctrl   (dec_ctrl)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_FETCH;
      Pc    <= '0;
    end else begin
      state <= state_next;
      Pc    <= pc_next;
    end
  end

  // Strobes come straight from the registered state, so reset clears them without a clock.
  always_comb begin
    state_next = state;
    pc_next    = Pc;
    exec_ctrl  = '0;
    Operand    = '0;
    Halted     = 1'b0;
    case (state)
      ST_FETCH: begin
        if (Enable) state_next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        Operand = Instr[OPERAND_WIDTH-1:0];
        if (Enable) begin
          exec_ctrl = dec_ctrl;
          if (opcode == OP_HLT) begin
            state_next = ST_HALT;
          end else begin
            pc_next    = Pc + PC_WIDTH'(1);
            state_next = ST_FETCH;
          end
        end
      end
      ST_HALT: Halted = 1'b1;
      default: state_next = ST_FETCH;
    endcase
  end

  assign SelA  = exec_ctrl.sel_a;
  assign SelB  = exec_ctrl.sel_b;
  assign OpSub = exec_ctrl.op_sub;
  assign WrAcc = exec_ctrl.wr_acc;
  assign WrRam = exec_ctrl.wr_ram;
  assign RdRam = exec_ctrl.rd_ram;

`ifdef BIP_CYCLE_COUNT_EN
  // Counts every enabled non-HALT cycle, including the HLT EXECUTE cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      CycleCount <= '0;
    end else if (Enable && (state != ST_HALT) && (CycleCount != {CNT_WIDTH{1'b1}})) begin
      CycleCount <= CycleCount + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
